status_flag_unit: RTL and testbench
===================================

// Module: status_flag_unit
// PURPOSE
// - Generates and holds the Z/C/S/O status flags that the branch-decision logic consumes for JZ/JB/JBE/JA/JAE/JG/JGE/JL/JLE.
// - Sits beside the ALU: computes flags from ALU operands and result, latches them on instruction commit, presents them registered.
// - Also provides a small shadow stack so flags survive interrupt entry/return, plus a direct flag load/read path for the PSW.
// PARAMETERS
// DATA_WIDTH   16  operand/result width in bits (>=4)
// STACK_DEPTH  4   entries in flag shadow stack (power of 2, >=2)
// PORTS
// clk            in   1           single system clock, rising edge
// reset_n        in   1           asynchronous active-low reset
// flag_op        in   3           flag_op_t: NONE, ADD, SUB, CMP, LOGIC, SHL, SHR, LOAD
// operand_a      in   DATA_WIDTH  ALU operand A
// operand_b      in   DATA_WIDTH  ALU operand B
// alu_result     in   DATA_WIDTH  ALU result for this op (CMP: A-B, not written back)
// shift_out_bit  in   1           last bit shifted out (SHL/SHR only)
// flag_update    in   1           commit strobe: latch flags for flag_op this cycle
// flag_load_data in   4           {O,S,C,Z} for flag_op==LOAD
// save_req       in   1           push current flags to shadow stack (interrupt entry)
// restore_req    in   1           pop shadow stack into flags (interrupt return)
// zero_flag      out  1           registered Z
// carry_flag     out  1           registered C (carry-out on ADD, borrow on SUB/CMP)
// sign_flag      out  1           registered S
// overflow_flag  out  1           registered O
// flags_valid    out  1           1 cycle pulse: flags changed this cycle
// stack_full     out  1           shadow stack holds STACK_DEPTH entries
// stack_empty    out  1           shadow stack holds 0 entries
// stack_error    out  1           sticky: push when full or pop when empty; cleared only by reset
// BEHAVIOUR
// - Reset (async, reset_n=0): Z=C=S=O=0, flags_valid=0, stack_error=0, stack pointer=0 (stack_empty=1, stack_full=0).
// - Latency: flag_update sampled at edge N -> new flags visible after edge N, i.e. usable by the branch decision in cycle N+1.
// - Flag rules (W=DATA_WIDTH):
//   ADD: Z=(result==0); S=result[W-1]; C=carry out of A+B (W+1-bit sum); O=(A[W-1]==B[W-1])&&(result[W-1]!=A[W-1]).
//   SUB/CMP: Z, S as ADD; C=(A<B unsigned); O=(A[W-1]!=B[W-1])&&(result[W-1]!=A[W-1]).
//   LOGIC: Z, S from result; C=0; O=0.
//   SHL/SHR: Z, S from result; C=shift_out_bit; O=0.
//   LOAD: {O,S,C,Z}=flag_load_data.
//   NONE: flags held; flags_valid stays 0 even if flag_update=1.
// - Flags hold value when no update/restore occurs.
// - Stack FSM-free: pointer counts 0..STACK_DEPTH. Push writes current flags (pre-update value of this cycle) at ptr, ptr++.
//   Pop loads entry ptr-1 into flags, ptr--, asserts flags_valid.
// - Push when full: ignored, stack_error set. Pop when empty: flags unchanged, stack_error set.
// - Same-cycle priority: restore_req > flag_update. save_req+restore_req together: treated as no-op on the stack, stack_error set.
// - save_req+flag_update together: push old flags, then latch new flags (both take effect).
// - Reset mid-sequence discards stack contents; no partial state survives.
// - flags_valid = 1 for exactly the cycle after any edge where flags were written (update or successful pop).
// STRUCTURE
// - Package cpu_flags_pkg: typedef enum logic[2:0] flag_op_t; typedef struct packed {o,s,c,z} flags_t; FLAG_W=4 constant.
// - One sub-module: flag_calc (purely combinational, op/operands/result -> flags_t); status_flag_unit holds regs and stack.
// - Stack: array of flags_t [STACK_DEPTH], pointer of $clog2(STACK_DEPTH)+1 bits.
// TESTING (DATA_WIDTH=16)
// - ADD 0xFFFF+0x0001, result 0x0000, update -> next cycle Z=1 C=1 S=0 O=0, flags_valid=1 for one cycle.
// - ADD 0x7FFF+0x0001, result 0x8000 -> Z=0 C=0 S=1 O=1; CMP 0x0003,0x0005, result 0xFFFE -> C=1 S=1 Z=0 O=0.
// - LOGIC result 0x0000 after carry set -> Z=1 C=0 O=0; flag_op=NONE with flag_update=1 -> flags unchanged, flags_valid=0.
// - LOAD 4'b1010, save x4 (stack_full=1), 5th save -> stack_error=1; restore x4 returns 4'b1010 each time, stack_empty=1.
// - Restore on empty -> flags unchanged, stack_error=1; restore_req+flag_update same cycle -> popped value wins.
// - Assert reset_n low mid-push sequence, asynchronously -> flags 0, stack_empty=1, stack_error=0 before next clk edge.

Source files
------------

// File: rtl/cpu_flags_pkg.sv
// Shared types for the status-flag logic.
//   flag_op_t : which flag rule applies to the op currently at commit
//   flags_t   : packed {o, s, c, z}, so bit order matches the PSW nibble {O,S,C,Z}
//   FLAG_W    : width of a packed flags_t
package cpu_flags_pkg;

  localparam int FLAG_W = 4;

  typedef enum logic [2:0] {
    FLAG_OP_NONE  = 3'd0,
    FLAG_OP_ADD   = 3'd1,
    FLAG_OP_SUB   = 3'd2,
    FLAG_OP_CMP   = 3'd3,
    FLAG_OP_LOGIC = 3'd4,
    FLAG_OP_SHL   = 3'd5,
    FLAG_OP_SHR   = 3'd6,
    FLAG_OP_LOAD  = 3'd7
  } flag_op_t;

  typedef struct packed {
    logic o;
    logic s;
    logic c;
    logic z;
  } flags_t;

endpackage

// File: rtl/flag_calc.sv
// Combinational flag generator. Derives the candidate Z/C/S/O value for one
// ALU operation from its operands and result; the caller decides whether the
// value is actually committed.
// Ports:
//   flag_op        : operation (flag_op_t encoding)
//   operand_a/b    : ALU operands
//   alu_result     : ALU result (A-B for SUB/CMP)
//   shift_out_bit  : last bit shifted out, used as carry for SHL/SHR
//   flag_load_data : {O,S,C,Z} taken verbatim for LOAD
//   flags_out      : candidate flags, packed {O,S,C,Z}
module flag_calc
  import cpu_flags_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [2:0]            flag_op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  shift_out_bit,
  input  logic [FLAG_W-1:0]     flag_load_data,
  output logic [FLAG_W-1:0]     flags_out
);

  localparam int MSB = DATA_WIDTH - 1;

  flag_op_t              op;
  flags_t                f;
  logic [DATA_WIDTH:0]   add_sum;
  logic                  res_zero;
  logic                  res_sign;

  assign op       = flag_op_t'(flag_op);
  // Widened sum so the carry out of the MSB is visible independent of the ALU.
  assign add_sum  = {1'b0, operand_a} + {1'b0, operand_b};
  assign res_zero = (alu_result == '0);
  assign res_sign = alu_result[MSB];

  always_comb begin
    f   = '0;
    f.z = res_zero;
    f.s = res_sign;
    unique case (op)
      FLAG_OP_ADD: begin
        f.c = add_sum[DATA_WIDTH];
        f.o = (operand_a[MSB] == operand_b[MSB]) && (res_sign != operand_a[MSB]);
      end
      FLAG_OP_SUB, FLAG_OP_CMP: begin
        // Carry reports a borrow, i.e. unsigned A < B.
        f.c = (operand_a < operand_b);
        f.o = (operand_a[MSB] != operand_b[MSB]) && (res_sign != operand_a[MSB]);
      end
      FLAG_OP_LOGIC: begin
        f.c = 1'b0;
        f.o = 1'b0;
      end
      FLAG_OP_SHL, FLAG_OP_SHR: begin
        f.c = shift_out_bit;
        f.o = 1'b0;
      end
      FLAG_OP_LOAD: begin
        f = flags_t'(flag_load_data);
      end
      default: begin
        // NONE: value is never committed, keep it quiet.
        f = '0;
      end
    endcase
  end

  assign flags_out = f;

endmodule

// File: rtl/status_flag_unit.sv
// Status flag register with interrupt shadow stack.
// Latches Z/C/S/O for the committing ALU op, exposes them registered to the
// branch logic, and keeps a small LIFO of flag snapshots for interrupt
// entry/return. A direct LOAD path lets the PSW write the flags.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   flag_op                : flag rule for the committing op (flag_op_t)
//   operand_a/b, alu_result, shift_out_bit : ALU side inputs for flag rules
//   flag_update            : commit strobe
//   flag_load_data         : {O,S,C,Z} for LOAD
//   save_req / restore_req : push / pop the shadow stack
//   zero/carry/sign/overflow_flag : registered flags
//   flags_valid            : high the cycle after any flag write
//   stack_full/stack_empty : shadow stack occupancy
//   stack_error            : sticky overflow/underflow/conflict indicator
module status_flag_unit
  import cpu_flags_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            flag_op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  shift_out_bit,
  input  logic                  flag_update,
  input  logic [3:0]            flag_load_data,
  input  logic                  save_req,
  input  logic                  restore_req,
  output logic                  zero_flag,
  output logic                  carry_flag,
  output logic                  sign_flag,
  output logic                  overflow_flag,
  output logic                  flags_valid,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  stack_error
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(STACK_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  flag_op_t          op;
  logic [FLAG_W-1:0] calc_flags;

  flags_t            flags_p1;
  logic              vld_p1;
  logic              err_p1;
  logic [PTR_W-1:0]  ptr_p1;
  flags_t            stack_mem [STACK_DEPTH];

  flags_t            flags_nxt;
  logic              vld_nxt;
  logic              err_nxt;
  logic [PTR_W-1:0]  ptr_nxt;

  logic              push_req, pop_req, conflict;
  logic              push_ok, pop_ok, upd_ok;
  logic              is_full, is_empty;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  assign op = flag_op_t'(flag_op);

  flag_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_flag_calc (
    .flag_op        (flag_op),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .alu_result     (alu_result),
    .shift_out_bit  (shift_out_bit),
    .flag_load_data (flag_load_data),
    .flags_out      (calc_flags)
  );

  assign is_full  = (ptr_p1 == PTR_FULL);
  assign is_empty = (ptr_p1 == '0);
  // Push slot is the pointer itself (only used when not full, so it fits);
  // pop slot is the entry just below the pointer.
  assign wr_idx   = IDX_W'(ptr_p1);
  assign rd_idx   = IDX_W'(ptr_p1 - PTR_ONE);

  // Simultaneous save and restore cancel each other on the stack.
  assign conflict = save_req & restore_req;
  assign push_req = save_req & ~restore_req;
  assign pop_req  = restore_req & ~save_req;
  assign push_ok  = push_req & ~is_full;
  assign pop_ok   = pop_req & ~is_empty;
  // Any restore request outranks a commit in the same cycle, even one that fails.
  assign upd_ok   = flag_update & ~restore_req & (op != FLAG_OP_NONE);

  always_comb begin
    flags_nxt = flags_p1;
    vld_nxt   = 1'b0;
    ptr_nxt   = ptr_p1;
    err_nxt   = err_p1 | conflict | (push_req & is_full) | (pop_req & is_empty);
    if (pop_ok) begin
      flags_nxt = stack_mem[rd_idx];
      vld_nxt   = 1'b1;
    end else if (upd_ok) begin
      flags_nxt = flags_t'(calc_flags);
      vld_nxt   = 1'b1;
    end
    if (push_ok) begin
      ptr_nxt = ptr_p1 + PTR_ONE;
    end else if (pop_ok) begin
      ptr_nxt = ptr_p1 - PTR_ONE;
    end
  end

  // ---- stage p1: architectural flags, stack pointer, status ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_p1 <= '0;
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      ptr_p1   <= '0;
    end else begin
      flags_p1 <= flags_nxt;
      vld_p1   <= vld_nxt;
      err_p1   <= err_nxt;
      ptr_p1   <= ptr_nxt;
    end
  end

  // Stack storage is data only; the pointer reset makes old entries unreachable.
  // A push saves the flags as they were before any same-cycle commit.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_mem[wr_idx] <= flags_p1;
    end
  end

  assign zero_flag     = flags_p1.z;
  assign carry_flag    = flags_p1.c;
  assign sign_flag     = flags_p1.s;
  assign overflow_flag = flags_p1.o;
  assign flags_valid   = vld_p1;
  assign stack_full    = is_full;
  assign stack_empty   = is_empty;
  assign stack_error   = err_p1;

endmodule

// File: tb/tb_status_flag_unit.sv
module tb_status_flag_unit;

  logic        clk;
  logic        reset_n;
  logic [2:0]  flag_op;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [15:0] alu_result;
  logic        shift_out_bit;
  logic        flag_update;
  logic [3:0]  flag_load_data;
  logic        save_req;
  logic        restore_req;
  logic        zero_flag, carry_flag, sign_flag, overflow_flag;
  logic        flags_valid, stack_full, stack_empty, stack_error;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] OP_NONE = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_CMP = 3'd3,
                         OP_LOGIC = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_LOAD = 3'd7;

  status_flag_unit #(.DATA_WIDTH(16), .STACK_DEPTH(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flag_op        (flag_op),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .alu_result     (alu_result),
    .shift_out_bit  (shift_out_bit),
    .flag_update    (flag_update),
    .flag_load_data (flag_load_data),
    .save_req       (save_req),
    .restore_req    (restore_req),
    .zero_flag      (zero_flag),
    .carry_flag     (carry_flag),
    .sign_flag      (sign_flag),
    .overflow_flag  (overflow_flag),
    .flags_valid    (flags_valid),
    .stack_full     (stack_full),
    .stack_empty    (stack_empty),
    .stack_error    (stack_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {O,S,C,Z}
  function automatic logic [7:0] flg();
    return {4'b0, overflow_flag, sign_flag, carry_flag, zero_flag};
  endfunction

  // {valid, full, empty, error}
  function automatic logic [7:0] sts();
    return {4'b0, flags_valid, stack_full, stack_empty, stack_error};
  endfunction

  task automatic idle();
    flag_op = OP_NONE; operand_a = '0; operand_b = '0; alu_result = '0;
    shift_out_bit = 1'b0; flag_update = 1'b0; flag_load_data = '0;
    save_req = 1'b0; restore_req = 1'b0;
  endtask

  // Apply one cycle of inputs, clock it, return to idle and sample 1 time unit later.
  task automatic step(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] res, input logic sob, input logic upd,
                      input logic [3:0] ld, input logic sv, input logic rs);
    flag_op = op; operand_a = a; operand_b = b; alu_result = res; shift_out_bit = sob;
    flag_update = upd; flag_load_data = ld; save_req = sv; restore_req = rs;
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", flg(), 8'h0);
    chk("reset_status", sts(), 8'h2);           // empty only
    reset_n = 1'b1;

    // ADD 0xFFFF + 0x0001 = 0x0000 : Z=1 C=1
    step(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
    chk("add_wrap_flags", flg(), 8'h3);
    chk("add_wrap_valid", {7'b0, flags_valid}, 8'h1);
    step(OP_NONE, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("valid_one_cycle", {7'b0, flags_valid}, 8'h0);
    chk("flags_hold", flg(), 8'h3);

    // ADD 0x7FFF + 0x0001 = 0x8000 : S=1 O=1
    step(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
    chk("add_ovf_flags", flg(), 8'hC);

    // CMP 3,5 -> 0xFFFE : S=1 C=1
    step(OP_CMP, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
    chk("cmp_borrow_flags", flg(), 8'h6);

    // LOGIC 0x0000 after carry set : Z=1 only
    step(OP_LOGIC, 16'h00F0, 16'h0F00, 16'h0000, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
    chk("logic_zero_flags", flg(), 8'h1);

    // NONE with flag_update : held, no valid
    step(OP_NONE, 16'h1234, 16'h5678, 16'h8000, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
    chk("none_hold_flags", flg(), 8'h1);
    chk("none_no_valid", {7'b0, flags_valid}, 8'h0);

    // SUB 0x8000 - 0x0001 = 0x7FFF : O=1 only
    step(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
    chk("sub_ovf_flags", flg(), 8'h8);

    // SHL result 0x8000, shifted-out bit 1 : S=1 C=1
    step(OP_SHL, 16'hC000, 16'h0001, 16'h8000, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    chk("shl_flags", flg(), 8'h6);

    // LOAD 1010 then fill the stack
    step(OP_LOAD, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 4'b1010, 1'b0, 1'b0);
    chk("load_flags", flg(), 8'hA);
    for (int i = 0; i < 4; i++) begin
      step(OP_NONE, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    end
    chk("stack_full_status", sts(), 8'h4);       // full, no error, no valid
    step(OP_NONE, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("push_full_error", sts(), 8'h5);         // full + error

    // Overwrite flags, then restore x4 : 1010 each time
    step(OP_LOAD, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 4'b0101, 1'b0, 1'b0);
    chk("load_0101", flg(), 8'h5);
    for (int i = 0; i < 4; i++) begin
      step(OP_NONE, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
      chk($sformatf("restore%0d_flags", i), flg(), 8'hA);
      chk($sformatf("restore%0d_valid", i), {7'b0, flags_valid}, 8'h1);
    end
    chk("restored_empty", sts(), 8'hB);          // valid, empty, error

    // save+update same cycle: old flags pushed, new flags latched
    step(OP_LOAD, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 4'b0011, 1'b1, 1'b0);
    chk("save_upd_flags", flg(), 8'h3);
    // restore+update same cycle: popped value wins
    step(OP_LOAD, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b1);
    chk("restore_wins_flags", flg(), 8'hA);
    chk("restore_wins_empty", {7'b0, stack_empty}, 8'h1);

    // Async reset in the middle of a push sequence
    step(OP_NONE, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    step(OP_NONE, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    save_req = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_flags", flg(), 8'h0);
    chk("async_rst_status", sts(), 8'h2);
    idle();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Restore on empty: flags unchanged, error set
    step(OP_LOAD, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0);
    chk("post_rst_load", flg(), 8'h6);
    step(OP_NONE, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("pop_empty_flags", flg(), 8'h6);
    chk("pop_empty_status", sts(), 8'h3);        // empty + error, no valid

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
